// File: rtl/data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter
//
// Round-robin arbiter and sequencer sharing one DATA_W-bit data bus between
// NUM_REQ requesters. A requester wins a grant for a burst of at most
// MAX_BURST transfers. The winner's data is registered onto the bus one cycle
// after each transfer. A rising edge on clear forces the bus to zero, drops
// any grant and resets the round-robin pointer.
//
// Ports:
//   clk        - clock, all state on the rising edge
//   reset_n    - asynchronous active-low reset
//   clear      - synchronous bus clear, acts on its rising edge
//   req        - per-requester request, bit i = requester i
//   req_data   - requester i data in slice [i*DATA_W +: DATA_W]
//   gnt        - registered one-hot grant, all-zero when idle
//   data_out   - registered bus data
//   data_valid - data_out carries a transfer this cycle
//   busy       - arbiter is granting or clearing
//
// Optional build macro: DATA_BUS_ARB_ASSERT_EN compiles concurrent
// assertions and a burst cover property; without it the RTL is identical.
// -----------------------------------------------------------------------------
module data_bus_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         data_out,
  output logic                      data_valid,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   NREQ_X     = (IDX_W + 1)'(NUM_REQ);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  ptr_nxt;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  owner_nxt;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W:0]    cand;
  logic              found;
  logic [CNT_W-1:0]  burst_cnt;
  logic [CNT_W-1:0]  burst_nxt;
  logic              clear_q;
  logic              clear_rise;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_nxt;
  logic              release_gnt;

  logic [DATA_W-1:0] slot [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign slot[g] = req_data[g*DATA_W +: DATA_W];
  end

  assign clear_rise = clear & ~clear_q;
  assign busy       = (state != ST_IDLE);

  // Stage: round-robin search, first set request at or after the pointer
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (cand >= NREQ_X) cand = cand - NREQ_X;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  // Stage: next-state, grant and bus data
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    burst_nxt   = burst_cnt;
    gnt_nxt     = gnt;
    data_nxt    = data_out;
    valid_nxt   = 1'b0;
    release_gnt = 1'b0;

    if (clear_rise) begin
      // Clear outranks arbitration and any transfer in flight this cycle.
      state_nxt = ST_CLEAR;
      ptr_nxt   = '0;
      burst_nxt = '0;
      gnt_nxt   = '0;
      data_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state_nxt       = ST_GRANT;
            owner_nxt       = winner;
            burst_nxt       = '0;
            gnt_nxt         = '0;
            gnt_nxt[winner] = 1'b1;
          end
        end
        ST_GRANT: begin
          if (req[owner]) begin
            data_nxt  = slot[owner];
            valid_nxt = 1'b1;
            burst_nxt = burst_cnt + 1'b1;
            if (burst_cnt == BURST_LAST) release_gnt = 1'b1;
          end else begin
            release_gnt = 1'b1;
          end
        end
        ST_CLEAR: begin
          if (!clear) state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
          gnt_nxt   = '0;
        end
      endcase

      // Returning to IDLE forces one cycle with no grant before the next win.
      if (release_gnt) begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
        ptr_nxt   = (owner == IDX_LAST) ? '0 : owner + 1'b1;
      end
    end
  end

  // Stage: registered outputs and control state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      owner      <= '0;
      burst_cnt  <= '0;
      clear_q    <= 1'b0;
      gnt        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      owner      <= owner_nxt;
      burst_cnt  <= burst_nxt;
      clear_q    <= clear;
      gnt        <= gnt_nxt;
      data_out   <= data_nxt;
      data_valid <= valid_nxt;
    end
  end

`ifdef DATA_BUS_ARB_ASSERT_EN
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(gnt))
    else $error("a_gnt_onehot0: gnt=%b is not one-hot or zero", gnt);

  a_clear_zero: assert property (@(posedge clk) disable iff (!reset_n)
    $rose(clear) |=> (data_out == '0))
    else $error("a_clear_zero: data_out=%h not zero after clear rise", data_out);

  a_valid_from_xfer: assert property (@(posedge clk) disable iff (!reset_n)
    data_valid |-> $past(|(gnt & req)))
    else $error("a_valid_from_xfer: data_valid without a granted request");

  a_grant_bounded: assert property (@(posedge clk) disable iff (!reset_n)
    not ((|gnt) [*MAX_BURST+2]))
    else $error("a_grant_bounded: grant held longer than MAX_BURST+1 cycles");

  c_full_burst: cover property (@(posedge clk) disable iff (!reset_n)
    (|(gnt & req)) [*MAX_BURST]);
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_bus_arbiter
//
// Self-checking bench for data_bus_arbiter. A transaction-level reference
// model (owner index, transfer count, clear flag) predicts the bus outputs
// every cycle; directed scenarios add fixed expectations on top.
// -----------------------------------------------------------------------------
module tb_data_bus_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 16;
  localparam int MAX_BURST = 4;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      clear;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         data_out;
  logic                      data_valid;
  logic                      busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_bus_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy)
  );

  // Reference model
  int                 m_owner;
  int                 m_ptr;
  int                 m_cnt;
  bit                 m_clearing;
  bit                 m_clear_prev;
  logic [NUM_REQ-1:0] m_gnt;
  logic [DATA_W-1:0]  m_data;
  logic               m_valid;
  logic               m_busy;

  function automatic void model_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0;
    m_clearing = 0; m_clear_prev = 0;
    m_gnt = '0; m_data = '0; m_valid = 1'b0; m_busy = 1'b0;
  endfunction

  function automatic void model_step();
    bit rise;
    rise = clear && !m_clear_prev;
    m_clear_prev = clear;
    m_valid = 1'b0;
    if (rise) begin
      m_clearing = 1; m_owner = -1; m_ptr = 0; m_cnt = 0; m_data = '0;
    end else if (m_clearing) begin
      if (!clear) m_clearing = 0;
    end else if (m_owner >= 0) begin
      bit done;
      done = 0;
      if (req[m_owner]) begin
        m_data  = req_data[m_owner*DATA_W +: DATA_W];
        m_valid = 1'b1;
        m_cnt++;
        if (m_cnt == MAX_BURST) done = 1;
      end else begin
        done = 1;
      end
      if (done) begin
        m_ptr   = (m_owner + 1) % NUM_REQ;
        m_owner = -1;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int i;
        i = (m_ptr + k) % NUM_REQ;
        if (m_owner < 0 && req[i]) begin
          m_owner = i;
          m_cnt   = 0;
        end
      end
    end
    m_gnt  = (m_owner >= 0) ? (NUM_REQ'(1) << m_owner) : '0;
    m_busy = m_clearing || (m_owner >= 0);
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    clear    = 1'b1;
    req      = '1;
    req_data = {$urandom, $urandom};
    model_reset();
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({gnt, data_out, data_valid, busy} !== '0) begin
        errors++;
        $display("FAIL reset_hold c%0d: gnt=%b data=%h valid=%b busy=%b, expected all zero",
                 c, gnt, data_out, data_valid, busy);
      end
      @(posedge clk);
      #1;
    end
    clear   = 1'b0;
    req     = '0;
    reset_n = 1'b1;
  endtask

  task automatic test_single_burst();
    logic [NUM_REQ-1:0] gexp [10] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
                                      4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    logic [DATA_W-1:0] got [$];
    int xfer_n = 0;
    req = 4'b0100;
    for (int t = 0; t < 10; t++) begin
      req_data = {$urandom, $urandom};
      req_data[2*DATA_W +: DATA_W] = 16'h0100 + DATA_W'(xfer_n);
      tick();
      if (m_valid) xfer_n++;
      if (data_valid) got.push_back(data_out);
      checks++;
      if ({gnt, data_out, data_valid, busy} !== {m_gnt, m_data, m_valid, m_busy}) begin
        errors++;
        $display("FAIL single_burst t%0d: gnt=%b data=%h valid=%b busy=%b, expected %b %h %b %b",
                 t, gnt, data_out, data_valid, busy, m_gnt, m_data, m_valid, m_busy);
      end
      checks++;
      if (gnt !== gexp[t]) begin
        errors++;
        $display("FAIL single_burst_gnt t%0d: gnt=%b, expected %b", t, gnt, gexp[t]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== 16'h0100 + DATA_W'(i)) begin
        errors++;
        $display("FAIL single_burst_data %0d: got %h (count %0d), expected %h",
                 i, (got.size() > i) ? got[i] : 16'hxxxx, got.size(), 16'h0100 + DATA_W'(i));
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int order [$];
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [NUM_REQ-1:0] prev;
    do_reset();
    prev = '0;
    req  = 4'hF;
    for (int t = 0; t < 25; t++) begin
      req_data = {$urandom, $urandom};
      tick();
      checks++;
      if ({gnt, data_out, data_valid, busy} !== {m_gnt, m_data, m_valid, m_busy}) begin
        errors++;
        $display("FAIL round_robin t%0d: gnt=%b data=%h valid=%b busy=%b, expected %b %h %b %b",
                 t, gnt, data_out, data_valid, busy, m_gnt, m_data, m_valid, m_busy);
      end
      if (gnt != '0 && prev == '0) begin
        for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) order.push_back(i);
      end
      prev = gnt;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (order.size() <= i || order[i] != exp_order[i]) begin
        errors++;
        $display("FAIL rr_order %0d: got %0d (grants seen %0d), expected %0d",
                 i, (order.size() > i) ? order[i] : -1, order.size(), exp_order[i]);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_early_drop();
    int nvalid = 0;
    do_reset();
    req = 4'b0010;
    for (int t = 0; t < 5; t++) begin
      if (t == 3) req = 4'b0000;
      if (t == 4) req = 4'b1010;
      req_data = {$urandom, $urandom};
      tick();
      if (data_valid) nvalid++;
      checks++;
      if ({gnt, data_out, data_valid, busy} !== {m_gnt, m_data, m_valid, m_busy}) begin
        errors++;
        $display("FAIL early_drop t%0d: gnt=%b data=%h valid=%b busy=%b, expected %b %h %b %b",
                 t, gnt, data_out, data_valid, busy, m_gnt, m_data, m_valid, m_busy);
      end
      if (t == 3) begin
        checks++;
        if (gnt !== 4'b0000 || nvalid != 2) begin
          errors++;
          $display("FAIL early_drop_release: gnt=%b transfers=%0d, expected 0000 and 2", gnt, nvalid);
        end
      end
    end
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL early_drop_next: gnt=%b, expected 1000", gnt);
    end
    req = '0;
    tick();
  endtask

  task automatic test_clear();
    int guard;
    do_reset();
    req = 4'b0001;
    req_data = {$urandom, $urandom};
    req_data[0 +: DATA_W] = 16'hBEEF;
    tick();
    tick();
    checks++;
    if (data_out !== 16'hBEEF || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL clear_setup: data=%h valid=%b, expected beef 1", data_out, data_valid);
    end
    clear = 1'b1;
    req   = 4'b1001;
    for (int t = 0; t < 6; t++) begin
      tick();
      checks++;
      if ({gnt, data_out, data_valid, busy} !== {4'b0000, 16'h0000, 1'b0, 1'b1} ||
          {gnt, data_out, data_valid, busy} !== {m_gnt, m_data, m_valid, m_busy}) begin
        errors++;
        $display("FAIL clear_hold t%0d: gnt=%b data=%h valid=%b busy=%b, expected 0000 0000 0 1",
                 t, gnt, data_out, data_valid, busy);
      end
    end
    clear = 1'b0;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt !== m_gnt) begin
      errors++;
      $display("FAIL clear_rearb: gnt=%b, expected 0001", gnt);
    end
    // Raise clear in the cycle carrying the last transfer of a burst.
    guard = 0;
    while (!(m_owner >= 0 && m_cnt == MAX_BURST - 1) && guard < 20) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      errors++;
      $display("FAIL clear_last_setup: burst end not reached in %0d cycles, expected < 20", guard);
    end
    req_data[0 +: DATA_W] = 16'h1234;
    clear = 1'b1;
    tick();
    checks++;
    if ({gnt, data_out, data_valid} !== {4'b0000, 16'h0000, 1'b0} ||
        {gnt, data_out, data_valid, busy} !== {m_gnt, m_data, m_valid, m_busy}) begin
      errors++;
      $display("FAIL clear_last_xfer: gnt=%b data=%h valid=%b, expected 0000 0000 0",
               gnt, data_out, data_valid);
    end
    clear = 1'b0;
    req   = '0;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0100;
    req_data = {$urandom, $urandom};
    tick();
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({gnt, data_out, data_valid, busy} !== '0) begin
      errors++;
      $display("FAIL async_reset: gnt=%b data=%h valid=%b busy=%b, expected all zero",
               gnt, data_out, data_valid, busy);
    end
    @(posedge clk);
    #1;
    req     = 4'hF;
    reset_n = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt !== m_gnt) begin
      errors++;
      $display("FAIL async_reset_restart: gnt=%b, expected 0001", gnt);
    end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    req   = '0;
    clear = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 3) == 0) req = NUM_REQ'($urandom);
      if (!clear && $urandom_range(0, 24) == 0) clear = 1'b1;
      else if (clear && $urandom_range(0, 3) == 0) clear = 1'b0;
      req_data = {$urandom, $urandom};
      tick();
      checks++;
      if ({gnt, data_out, data_valid, busy} !== {m_gnt, m_data, m_valid, m_busy}) begin
        errors++;
        $display("FAIL random t%0d: gnt=%b data=%h valid=%b busy=%b, expected %b %h %b %b",
                 t, gnt, data_out, data_valid, busy, m_gnt, m_data, m_valid, m_busy);
      end
    end
    clear = 1'b0;
    req   = '0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_early_drop();
    test_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one DATA_W-bit data bus between NUM_REQ requesters.
- Grants one requester at a time for a bounded burst and registers the winner's data onto the bus.
- A clear input forces the bus to zero. The bus-zero-on-clear rule is the invariant the monitors check, and this block guarantees it.
- Sits between requester blocks and the shared data consumer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 16, data bus width
MAX_BURST, 4, maximum transfers per grant (>=1)

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
clear  in  1  synchronous bus clear; acts on its rising edge
req  in  NUM_REQ  per-requester request; bit i = requester i
req_data  in  NUM_REQ*DATA_W  requester i data in slice [i*DATA_W +: DATA_W]
gnt  out  NUM_REQ  registered one-hot grant (all-zero when idle)
data_out  out  DATA_W  registered bus data
data_valid  out  1  data_out holds a transfer this cycle
busy  out  1  state != IDLE

Behaviour:
- Reset (reset_n low, asynchronous) sets:
  - gnt = 0, data_out = 0, data_valid = 0, busy = 0
  - state = IDLE, rr pointer = 0, burst_cnt = 0, clear_q = 0
- States:
  - IDLE -> GRANT: any req bit high. Winner is the first set bit at or after the pointer, wrapping modulo NUM_REQ. gnt[winner] = 1 from the next cycle; burst_cnt = 0.
  - GRANT -> IDLE: on grant release (see below). gnt = 0 next cycle and pointer = (winner+1) mod NUM_REQ. One mandatory idle cycle follows before any re-arbitration.
  - any -> CLEAR: clear_rise = clear & ~clear_q. Highest priority; overrides arbitration and transfers in the same cycle.
  - CLEAR -> IDLE: when clear is low. CLEAR is held while clear stays high.
- Transfer and latency:
  - A transfer occurs in a cycle where gnt[i] & req[i].
  - Next edge: data_out = req_data[i], data_valid = 1, burst_cnt + 1. Latency is one cycle.
  - In any non-transfer cycle, data_valid = 0 and data_out holds its last value.
- Grant release (evaluated in GRANT):
  - req[winner] low: no transfer that cycle, release.
  - Transfer that makes burst_cnt reach MAX_BURST: transfer completes, release at the same edge.
- Clear:
  - On the edge after clear_rise: data_out = 0, data_valid = 0, gnt = 0, pointer = 0, burst_cnt = 0.
  - Invariant: $rose(clear) |=> data_out == 0.
  - While in CLEAR, req is ignored.
- Boundaries:
  - A requester dropping req while not granted: no effect.
  - Pointer wraps NUM_REQ-1 -> 0.
  - clear held high for many cycles: one clear action, then stays in CLEAR.
  - clear_rise coincident with the last burst transfer: clear wins and no data is transferred.
  - reset_n asserted mid-burst: outputs go to reset values immediately, with no clock needed.
- gnt is always one-hot or zero. burst_cnt width = $clog2(MAX_BURST+1).

Optional Feature:
- Macro: DATA_BUS_ARB_ASSERT_EN.
- Defined: the module includes concurrent assertions, all disabled iff !reset_n:
  - $onehot0(gnt)
  - $rose(clear) |=> data_out == 0
  - data_valid |-> $past(|(gnt & req))
  - no grant longer than MAX_BURST+1 cycles
  - Plus a cover property on a full MAX_BURST burst.
  - Failures report through $error, with a fail-action block naming the property.
- Undefined: no assertion code is compiled; RTL behaviour is identical.

Test Plan:
1. reset_n low with req = 4'hF and clear = 1 -> gnt = 0, data_out = 16'h0000, data_valid = 0, busy = 0. These hold until reset_n rises.
2. req[2] held 10 cycles with req_data[2] counting 16'h0100.. ->
   - gnt = 4'b0100 for 4 transfers, data_out = 16'h0100..16'h0103 one cycle after each transfer;
   - then one idle cycle, then re-grant to requester 2.
3. req = 4'hF held continuously -> grant order 0,1,2,3,0. Each grant gives 4 transfers with one idle cycle between grants.
4. req[1] granted, dropped after 2 transfers -> gnt released after 2 transfers, pointer = 2. Next request from 3 or 2 is served before 1.
5. Mid-burst, data_out = 16'hBEEF, clear rises ->
   - next cycle: data_out = 16'h0000, gnt = 0, data_valid = 0;
   - after clear falls with req = 4'b1001, requester 0 wins.
6. reset_n pulsed low mid-burst between clock edges -> outputs are zero before the next edge. After release, arbitration restarts at requester 0.
